// File: rtl/xy_div_seq.sv
// xy_div_seq: memory-mapped unsigned divider peripheral. A restoring divider
// produces one quotient bit per clock, so a division takes WIDTH clocks after
// START.
//
// Ports:
//   CLK    clock, every state update happens on its rising edge
//   RST_N  asynchronous active-low reset
//   E      bus enable (R and W are ignored while E=0)
//   R, W   read and write strobes
//   ADDR   register select: 0=X, 1=Y, 2=RESULT {rem,quot}, 3=CTRL/STATUS
//   D      write data (X/Y use the low WIDTH bits, CTRL uses D[0] START)
//   OUT    registered read data
//   BUSY   high while the divider is iterating
//   IRQ    completion interrupt (only when XY_DIV_SEQ_IRQ_EN is defined)
//
// Build option XY_DIV_SEQ_IRQ_EN adds the IRQ output and the IE control bit
// (CTRL D[1], status OUT[3]); CTRL D[2]=1 acknowledges the interrupt.
//
// state | meaning
// IDLE  | no division since reset
// RUN   | iterating, one quotient bit per clock, BUSY=1
// ZDIV  | START with Y==0 accepted, results posted on the next clock
// DONE  | results valid, waiting for the next START

module xy_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        E,
    input  logic        R,
    input  logic        W,
    input  logic [1:0]  ADDR,
    input  logic [15:0] D,
    output logic [31:0] OUT,
    output logic        BUSY
`ifdef XY_DIV_SEQ_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZDIV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    // quot_q starts out holding the dividend; quotient bits shift in at the
    // bottom while dividend bits shift out of the top into the remainder.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [31:0]      out_q, out_d;

    logic             wr_en;
    logic             rd_en;
    logic             busy;
    logic             start;
    logic             ie_bit;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   div_ext;
    logic             unused_d;

    assign wr_en     = E & W;
    assign rd_en     = E & R;
    assign busy      = (state_q == S_RUN);
    assign start     = wr_en && (ADDR == 2'd3) && D[0] &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));
    assign rem_shift = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    assign div_ext   = {1'b0, y_q};
    // Upper data bits carry nothing for narrow builds.
    assign unused_d  = ^D;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        dz_d    = dz_q;
        out_d   = out_q;

        if (wr_en && !busy) begin
            if (ADDR == 2'd0) x_d = D[WIDTH-1:0];
            if (ADDR == 2'd1) y_d = D[WIDTH-1:0];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    quot_d  = x_q;
                    rem_d   = '0;
                    cnt_d   = CNT_LAST;
                    done_d  = 1'b0;
                    dz_d    = 1'b0;
                    state_d = (y_q == '0) ? S_ZDIV : S_RUN;
                end
            end
            S_RUN: begin
                if (rem_shift >= div_ext) begin
                    rem_d  = rem_shift - div_ext;
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_ZDIV: begin
                // quot_q still holds the latched dividend here.
                rem_d   = {1'b0, quot_q};
                quot_d  = '1;
                dz_d    = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reads see pre-edge register values, so a same-edge write is not visible.
        if (rd_en) begin
            case (ADDR)
                2'd0:    out_d = 32'(x_q);
                2'd1:    out_d = 32'(y_q);
                2'd2:    out_d = {16'(rem_q[WIDTH-1:0]), 16'(quot_q)};
                default: out_d = {28'd0, ie_bit, dz_q, done_q, busy};
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            out_q   <= out_d;
        end
    end

    assign OUT  = out_q;
    assign BUSY = busy;

`ifdef XY_DIV_SEQ_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    always_comb begin
        ie_d  = ie_q;
        irq_d = irq_q;
        if (wr_en && (ADDR == 2'd3)) begin
            ie_d = D[1];
            if (D[2]) irq_d = 1'b0;
        end
        if (start) irq_d = 1'b0;
        // Completion after acknowledge so that set wins on a shared edge.
        if (done_d && !done_q && ie_q) irq_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_bit = ie_q;
    assign IRQ    = irq_q;
`else
    assign ie_bit = 1'b0;
`endif

endmodule

// File: tb/tb_xy_div_seq.sv
module tb_xy_div_seq;

    localparam int WIDTH = 16;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b1;
    logic        E     = 1'b0;
    logic        R     = 1'b0;
    logic        W     = 1'b0;
    logic [1:0]  ADDR  = 2'd0;
    logic [15:0] D     = 16'd0;
    logic [31:0] OUT;
    logic        BUSY;
`ifdef XY_DIV_SEQ_IRQ_EN
    logic        IRQ;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    xy_div_seq #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .E    (E),
        .R    (R),
        .W    (W),
        .ADDR (ADDR),
        .D    (D),
        .OUT  (OUT),
        .BUSY (BUSY)
`ifdef XY_DIV_SEQ_IRQ_EN
        ,
        .IRQ  (IRQ)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, completion countdown and the
    // quotient/remainder computed with plain / and %.
    logic [15:0] mx, my, lx, ly, mq, mr;
    bit          mdone, mdz, mzp, mie, mirq, mknown;
    int          mbusy;
    logic [31:0] mout;

    function automatic void model_reset();
        mx = 0; my = 0; lx = 0; ly = 0; mq = 0; mr = 0;
        mdone = 0; mdz = 0; mzp = 0; mie = 0; mirq = 0;
        mbusy = 0; mout = 0; mknown = 1;
    endfunction

    initial model_reset();

    always @(posedge CLK) begin : cmp
        bit          wr, rd, busy_pre, start, fin, ie_pre;
        logic [31:0] rv;
        bit          rv_ok;
        if (!RST_N) begin
            model_reset();
            #1;
            chk("rst_out", OUT, 32'h0);
            chk("rst_busy", 32'(BUSY), 32'h0);
        end else begin
            wr       = E && W;
            rd       = E && R;
            busy_pre = (mbusy > 0);
            ie_pre   = mie;
            if (rd) begin
                rv_ok = 1;
                case (ADDR)
                    2'd0: rv = {16'h0, mx};
                    2'd1: rv = {16'h0, my};
                    2'd2: begin rv = {mr, mq}; rv_ok = !busy_pre && !mzp; end
                    default: begin rv = {28'h0, mie, mdz, mdone, busy_pre}; rv_ok = !mzp; end
                endcase
                mout   = rv;
                mknown = rv_ok;
            end
            start = wr && (ADDR == 2'd3) && D[0] && !busy_pre && !mzp;
            fin   = 0;
            if (wr && !busy_pre) begin
                if (ADDR == 2'd0) mx = D;
                if (ADDR == 2'd1) my = D;
            end
            if (mbusy > 0) begin
                mbusy--;
                if (mbusy == 0) begin
                    mq = lx / ly; mr = lx % ly; mdone = 1; fin = 1;
                end
            end else if (mzp) begin
                mzp = 0; mq = 16'hFFFF; mr = lx; mdone = 1; mdz = 1; fin = 1;
            end
`ifdef XY_DIV_SEQ_IRQ_EN
            if (wr && (ADDR == 2'd3)) begin
                mie = D[1];
                if (D[2]) mirq = 0;
            end
            if (start) mirq = 0;
            if (fin && ie_pre) mirq = 1;
`endif
            if (start) begin
                lx = mx; ly = my; mdone = 0; mdz = 0;
                if (my == 16'h0) mzp = 1;
                else mbusy = WIDTH;
            end
            #1;
            chk("busy", 32'(BUSY), 32'(mbusy > 0));
            if (mknown) chk("out", OUT, mout);
`ifdef XY_DIV_SEQ_IRQ_EN
            chk("irq", 32'(IRQ), 32'(mirq));
`endif
        end
    end

    task automatic cyc(input bit e, input bit r, input bit w, input logic [1:0] a, input logic [15:0] d);
        E = e; R = r; W = w; ADDR = a; D = d;
        @(posedge CLK);
        #2;
        E = 0; R = 0; W = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cyc(1, 0, 1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1, 1, 0, a, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 16'h0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY && n < 100) begin
            n++;
            idle(1);
        end
        if (BUSY) chk("busy_timeout", 32'(BUSY), 32'h0);
    endtask

    task automatic async_reset();
        #3;
        RST_N = 0;
        model_reset();
        #1;
        chk("async_busy", 32'(BUSY), 32'h0);
        chk("async_out", OUT, 32'h0);
        @(posedge CLK);
        #2;
        RST_N = 1;
    endtask

    initial begin
        int n;
        logic [15:0] d;
        #1 RST_N = 0;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1;

        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk("reset_read", OUT, 32'h0);
        end
        chk("reset_busy", 32'(BUSY), 32'h0);

        wr(2'd0, 16'd100);
        wr(2'd1, 16'd7);
        wr(2'd3, 16'h0001);
        wait_idle(n);
        chk("busy_len", 32'(n), 32'd16);
        rd(2'd3);
        chk("status_100_7", OUT, 32'h0000_0002);
        rd(2'd2);
        chk("result_100_7", OUT, 32'h0002_000E);

        wr(2'd0, 16'hFFFF);
        wr(2'd1, 16'd1);
        wr(2'd3, 16'h0001);
        wait_idle(n);
        rd(2'd2);
        chk("result_ffff_1", OUT, 32'h0000_FFFF);
        rd(2'd3);
        chk("status_ffff_1", OUT, 32'h0000_0002);
        wr(2'd0, 16'd5);
        wr(2'd1, 16'd0);
        wr(2'd3, 16'h0001);
        chk("dz_busy", 32'(BUSY), 32'h0);
        idle(1);
        rd(2'd3);
        chk("status_dz", OUT, 32'h0000_0006);
        rd(2'd2);
        chk("result_dz", OUT, 32'h0005_FFFF);

        wr(2'd0, 16'd200);
        wr(2'd1, 16'd10);
        wr(2'd3, 16'h0001);
        idle(4);
        wr(2'd0, 16'd3);
        wr(2'd1, 16'd1);
        wr(2'd3, 16'h0001);
        wait_idle(n);
        rd(2'd2);
        chk("result_200_10", OUT, 32'h0000_0014);
        rd(2'd0);
        chk("x_kept", OUT, 32'd200);

        wr(2'd0, 16'd1000);
        wr(2'd1, 16'd3);
        wr(2'd3, 16'h0001);
        rd(2'd0);
        chk("x_1000", OUT, 32'd1000);
        idle(6);
        async_reset();
        rd(2'd3);
        chk("post_rst_status", OUT, 32'h0);
        rd(2'd2);
        chk("post_rst_result", OUT, 32'h0);

`ifdef XY_DIV_SEQ_IRQ_EN
        wr(2'd3, 16'h0002);
        wr(2'd0, 16'd9);
        wr(2'd1, 16'd2);
        wr(2'd3, 16'h0003);
        wait_idle(n);
        chk("irq_set", 32'(IRQ), 32'h1);
        rd(2'd2);
        chk("result_9_2", OUT, 32'h0001_0004);
        rd(2'd3);
        chk("status_ie", OUT, 32'h0000_000A);
        wr(2'd3, 16'h0004);
        chk("irq_ack", 32'(IRQ), 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) d = 16'($urandom_range(0, 3));
            cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d);
            if (i == 1500) async_reset();
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
